circuito_seq_ctrl: RTL and testbench
====================================

CIRCUITO_SEQ_CTRL -- requirements
Module: circuito_seq_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, schedule/result entries (power of two, 2..16); AW = log2(DEPTH).
REQ-002 Parameter SETTLE, default 2, settle cycles per day before capture (>=1).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 cfg_we  in  1  schedule write strobe.
REQ-006 cfg_addr  in  AW  schedule write index.
REQ-007 cfg_code  in  4  day code {A,B,C,D}.
REQ-008 cfg_len  in  AW+1  number of days to run.
REQ-009 start  in  1  run request, sampled each cycle.
REQ-010 busy  out  1  high from the cycle after accepted start through the DONE state.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 dut_abcd  out  4  registered drive to circuit under control {A,B,C,D}.
REQ-013 dut_xyz  in  3  circuit response {Z,Y,X}.
REQ-014 res_addr  in  AW  result read index.
REQ-015 res_data  out  3  result[res_addr], combinational read of registered storage.

Function
REQ-016 FSM states IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-017 IDLE: cfg_we=1 writes cfg_code into sched[cfg_addr]; start=1 latches len=min(cfg_len,DEPTH), idx=0, goes to APPLY if len!=0, else DONE.
REQ-018 APPLY (1 cycle): dut_abcd <= sched[idx]; reset settle counter; -> SETTLE.
REQ-019 SETTLE: held exactly SETTLE cycles with dut_abcd stable; -> CAPTURE.
REQ-020 CAPTURE (1 cycle): result[idx] <= dut_xyz; if idx==len-1 -> DONE, else idx+1, -> APPLY.
REQ-021 DONE (1 cycle): done=1, dut_abcd <= 4'b0000; -> IDLE.
REQ-022 Latency: start sampled at edge 0 -> done high in cycle len*(SETTLE+2)+1; len=0 -> done in cycle 1, no result written.
REQ-023 start and cfg_we while busy are ignored (no restart, schedule unchanged).
REQ-024 dut_abcd is 4'b0000 whenever in IDLE or DONE.
REQ-025 Results not overwritten by a run keep prior values; readable at any time, including while busy.
REQ-026 idx never exceeds DEPTH-1; cfg_len > DEPTH clamps to DEPTH.

Reset
REQ-027 rst_n low: state=IDLE, busy=0, done=0, dut_abcd=0000, idx=0, counter=0, all sched entries=0000, all results=000, immediately (asynchronous).
REQ-028 Reset mid-run aborts the run with no done pulse; first start after release runs from idx 0.

Structure
REQ-029 Package circuito_pkg holds the state enum, default DEPTH/SETTLE, and code/result width constants (4, 3).
REQ-030 One sub-module, circuito_seq_mem: DEPTH x 4 schedule store plus DEPTH x 3 result store, async reset, one write port each, combinational reads.
REQ-031 The combinational circuit stays outside this block; the bench instantiates it on dut_abcd/dut_xyz.

Verification
REQ-032 Load 0010,1011,1111,1010,1100 into entries 0..4, cfg_len=5, start -> done exactly at cycle 21, res_data[0..4] equal the circuit's {Z,Y,X} for each code.
REQ-033 Same run: dut_abcd shows each code for exactly 4 cycles (SETTLE=2), then 0000 at done.
REQ-034 cfg_len=0, start -> done at cycle 1, busy never high, results unchanged.
REQ-035 cfg_len=12 with DEPTH=8 -> 8 days run, done at cycle 33.
REQ-036 start and cfg_we to entry 0 pulsed during busy -> no restart, sched[0] unchanged, done once.
REQ-037 rst_n low during day 3 -> outputs zero at once, no done; subsequent start with len=2 completes at cycle 9.

Source files
------------

// File: rtl/circuito_pkg.sv
// Shared types and constants for the circuit sequencing controller.
package circuito_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_SETTLE = 2;
  localparam int CODE_W     = 4;
  localparam int RES_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/circuito_seq_mem.sv
// Schedule store (codes to drive) and result store (captured responses).
module circuito_seq_mem
  import circuito_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sched_we,
  input  logic [AW-1:0]     sched_waddr,
  input  logic [CODE_W-1:0] sched_wdata,
  input  logic [AW-1:0]     sched_raddr,
  output logic [CODE_W-1:0] sched_rdata,
  input  logic              res_we,
  input  logic [AW-1:0]     res_waddr,
  input  logic [RES_W-1:0]  res_wdata,
  input  logic [AW-1:0]     res_raddr,
  output logic [RES_W-1:0]  res_rdata
);

  logic [CODE_W-1:0] sched [DEPTH];
  logic [RES_W-1:0]  res   [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        sched[i] <= '0;
        res[i]   <= '0;
      end
    end else begin
      if (sched_we) sched[sched_waddr] <= sched_wdata;
      if (res_we)   res[res_waddr]     <= res_wdata;
    end
  end

  assign sched_rdata = sched[sched_raddr];
  assign res_rdata   = res[res_raddr];

endmodule

// File: rtl/circuito_seq_ctrl.sv
// Steps a circuit through a stored schedule of input codes and records
// its response to each code after a fixed settle time.
//
// state   | meaning
// IDLE    | accept schedule writes, wait for start
// APPLY   | code for this day already driven; load settle timer
// SETTLE  | hold drive stable for SETTLE cycles
// CAPTURE | record response, drive next code or finish
// DONE    | one-cycle done pulse, drive forced to zero
module circuito_seq_ctrl
  import circuito_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SETTLE = DEF_SETTLE,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CODE_W-1:0] cfg_code,
  input  logic [AW:0]       cfg_len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] dut_abcd,
  input  logic [RES_W-1:0]  dut_xyz,
  input  logic [AW-1:0]     res_addr,
  output logic [RES_W-1:0]  res_data
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t            state;
  logic [AW-1:0]     idx;
  logic [AW:0]       len;
  logic [CW-1:0]     cnt;
  logic [AW:0]       len_clamped;
  logic              last_day;
  logic              sched_we;
  logic              res_we;
  logic [AW-1:0]     sched_raddr;
  logic [CODE_W-1:0] sched_rdata;

  // The next code is fetched one step early so it is already on the pins
  // for the whole APPLY/SETTLE/CAPTURE window of its day.
  always_comb begin
    len_clamped = (cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_len;
    last_day    = ({1'b0, idx} == (len - (AW+1)'(1)));
    sched_we    = cfg_we && (state == ST_IDLE);
    res_we      = (state == ST_CAPTURE);
    sched_raddr = (state == ST_CAPTURE) ? idx + AW'(1) : idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      dut_abcd <= '0;
      idx      <= '0;
      len      <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len <= len_clamped;
            idx <= '0;
            if (len_clamped != '0) begin
              state    <= ST_APPLY;
              busy     <= 1'b1;
              dut_abcd <= sched_rdata;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          cnt   <= CW'(SETTLE - 1);
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == '0) state <= ST_CAPTURE;
          else           cnt   <= cnt - CW'(1);
        end
        ST_CAPTURE: begin
          if (last_day) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            dut_abcd <= '0;
          end else begin
            idx      <= idx + AW'(1);
            state    <= ST_APPLY;
            dut_abcd <= sched_rdata;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          idx   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  circuito_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk         (clk),
    .rst_n       (rst_n),
    .sched_we    (sched_we),
    .sched_waddr (cfg_addr),
    .sched_wdata (cfg_code),
    .sched_raddr (sched_raddr),
    .sched_rdata (sched_rdata),
    .res_we      (res_we),
    .res_waddr   (idx),
    .res_wdata   (dut_xyz),
    .res_raddr   (res_addr),
    .res_rdata   (res_data)
  );

endmodule

// File: tb/tb_circuito_seq_ctrl.sv
// Bench for circuito_seq_ctrl: directed table, corner sequences and random runs.
module tb_circuito_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DAY   = 4; // SETTLE(2) + APPLY + CAPTURE

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_addr = '0;
  logic [3:0] cfg_code = '0;
  logic [3:0] cfg_len = '0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [3:0] dut_abcd;
  logic [2:0] dut_xyz;
  logic [2:0] res_addr = '0;
  logic [2:0] res_data;

  int checks = 0;
  int failures = 0;

  logic [3:0] sched_m [DEPTH];
  logic [2:0] res_m   [DEPTH];

  typedef struct {
    logic [2:0] addr;
    logic [3:0] code;
    logic [2:0] exp_xyz;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  // Circuit under control: X = A^B, Y = B&C | D, Z = ~(B^D); response {Z,Y,X}.
  function automatic logic [2:0] circ(input logic [3:0] abcd);
    logic a, b, c, d;
    {a, b, c, d} = abcd;
    return {~(b ^ d), (b & c) | d, a ^ b};
  endfunction

  assign dut_xyz = circ(dut_abcd);

  circuito_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_code (cfg_code),
    .cfg_len  (cfg_len),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .dut_abcd (dut_abcd),
    .dut_xyz  (dut_xyz),
    .res_addr (res_addr),
    .res_data (res_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_sched(input int addr, input logic [3:0] code);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_code = code;
    @(negedge clk);
    cfg_we = 1'b0;
    sched_m[addr] = code;
  endtask

  task automatic check_results(input string name);
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      res_addr = 3'(i);
      #1;
      if (res_data !== res_m[i]) begin
        bad++;
        $display("FAIL %s: res[%0d] got %0h expected %0h", name, i, res_data, res_m[i]);
      end
    end
    checks++;
    if (bad != 0) failures++;
    res_addr = 3'd7;
  endtask

  // One run from idle; inj>0 pulses start and a write to entry 0 in that cycle.
  task automatic run(input string name, input int len_req, input int inj);
    int l, d, first_done, n_done, busy_err, abcd_err;
    logic exp_busy;
    logic [3:0] exp_abcd;
    logic [2:0] prior7;
    l = (len_req > DEPTH) ? DEPTH : len_req;
    d = (l == 0) ? 1 : l * DAY + 1;
    first_done = 0; n_done = 0; busy_err = 0; abcd_err = 0;
    res_addr = 3'd7;
    prior7 = res_m[7];
    @(negedge clk);
    cfg_len = 4'(len_req); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= d + 3; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = cyc;
      end
      exp_busy = (l > 0) && (cyc <= d);
      if (busy !== exp_busy) busy_err++;
      exp_abcd = (l > 0 && cyc < d) ? sched_m[(cyc - 1) / DAY] : 4'h0;
      if (dut_abcd !== exp_abcd) begin
        abcd_err++;
        if (abcd_err == 1)
          $display("FAIL %s_abcd: cycle %0d got %0h expected %0h", name, cyc, dut_abcd, exp_abcd);
      end
      if (cyc == 2) chk({name, "_res_while_busy"}, 32'(res_data), 32'(prior7));
      if (cyc == inj) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd0; cfg_code = ~sched_m[0];
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
    end
    chk({name, "_done_cycle"}, 32'(first_done), 32'(d));
    chk({name, "_done_count"}, 32'(n_done), 32'd1);
    chk({name, "_busy_trace_errs"}, 32'(busy_err), 32'd0);
    checks++;
    if (abcd_err != 0) failures++;
    for (int i = 0; i < l; i++) res_m[i] = circ(sched_m[i]);
    check_results({name, "_results"});
  endtask

  initial begin
    int seen_done;
    for (int i = 0; i < DEPTH; i++) begin sched_m[i] = '0; res_m[i] = '0; end
    vecs[0] = '{3'd0, 4'b0010, 3'b100};
    vecs[1] = '{3'd1, 4'b1011, 3'b011};
    vecs[2] = '{3'd2, 4'b1111, 3'b110};
    vecs[3] = '{3'd3, 4'b1010, 3'b101};
    vecs[4] = '{3'd4, 4'b1100, 3'b000};

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_abcd", 32'(dut_abcd), 32'd0);
    check_results("rst_results");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed five-day schedule
    foreach (vecs[i]) write_sched(vecs[i].addr, vecs[i].code);
    run("five_day", 5, 0);
    foreach (vecs[i]) begin
      res_addr = vecs[i].addr;
      #1;
      chk($sformatf("table_res%0d", i), 32'(res_data), 32'(vecs[i].exp_xyz));
    end

    run("len0", 0, 0);
    run("len12_clamp", 12, 0);
    run("busy_ignore", 5, 6);
    run("after_ignore", 1, 0);

    // Reset in the third day
    foreach (vecs[i]) write_sched(vecs[i].addr, vecs[i].code);
    @(negedge clk);
    cfg_len = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0;
    for (int cyc = 2; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_abcd", 32'(dut_abcd), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin sched_m[i] = '0; res_m[i] = '0; end
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1) seen_done++;
    end
    rst_n = 1'b1;
    chk("midrst_no_done", 32'(seen_done), 32'd0);
    check_results("midrst_results");
    write_sched(0, 4'b0110);
    write_sched(1, 4'b1001);
    run("post_rst_len2", 2, 0);

    // Randomized runs against the model
    for (int it = 0; it < 6; it++) begin
      int n, len;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) write_sched($urandom_range(0, DEPTH - 1), 4'($urandom));
      len = $urandom_range(0, 12);
      run($sformatf("rand%0d", it), len, (len >= 2) ? $urandom_range(2, 8) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
